// File: rtl/half_vec_add.sv
// Element-wise binary16 vector adder: WIDTH parallel combinational adders feeding one result register bank.
// Optional macro HALF_VEC_ADD_FTZ_EN flushes subnormal inputs and results to signed zero.
module half_vec_add #(
  parameter int WIDTH = 50
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [15:0] vector_a [WIDTH],
  input  logic [15:0] vector_b [WIDTH],
  output logic        done,
  output logic [15:0] vector_c [WIDTH]
);

  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic        sa, sb, a_nan, b_nan, a_inf, b_inf, swap, sl, st, rnd;
    logic [4:0]  ea, eb, ea_eff, eb_eff, el, es, diff, lim, sh;
    logic [9:0]  fa, fb;
    logic [10:0] ma, mb, ml, msm;
    logic [13:0] ext, shf, m14;
    logic [14:0] sum;
    logic [3:0]  lz;
    logic [5:0]  en;
    logic [15:0] pre, res;
    sa    = a[15];
    sb    = b[15];
    ea    = a[14:10];
    eb    = b[14:10];
    fa    = a[9:0];
    fb    = b[9:0];
    a_nan = (ea == 5'd31) && (fa != 10'd0);
    b_nan = (eb == 5'd31) && (fb != 10'd0);
    a_inf = (ea == 5'd31) && (fa == 10'd0);
    b_inf = (eb == 5'd31) && (fb == 10'd0);
`ifdef HALF_VEC_ADD_FTZ_EN
    fa = (ea == 5'd0) ? 10'd0 : fa;
    fb = (eb == 5'd0) ? 10'd0 : fb;
`endif
    // Subnormals share the exponent of the smallest normal, without the hidden bit.
    ea_eff = (ea == 5'd0) ? 5'd1 : ea;
    eb_eff = (eb == 5'd0) ? 5'd1 : eb;
    ma     = {(ea != 5'd0), fa};
    mb     = {(eb != 5'd0), fb};
    swap   = {eb_eff, mb} > {ea_eff, ma};
    sl     = swap ? sb : sa;
    el     = swap ? eb_eff : ea_eff;
    es     = swap ? ea_eff : eb_eff;
    ml     = swap ? mb : ma;
    msm    = swap ? ma : mb;
    diff   = el - es;
    ext    = {msm, 3'b000};
    if (diff >= 5'd14) begin
      shf = 14'd0;
      st  = |ext;
    end else begin
      shf = ext >> diff;
      st  = |(ext & ~(14'h3FFF << diff));
    end
    shf[0] = shf[0] | st;
    sum = (sa == sb) ? ({1'b0, ml, 3'b000} + {1'b0, shf})
                     : ({1'b0, ml, 3'b000} - {1'b0, shf});
    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (sum[i]) lz = 4'(13 - i);
    end
    lim = el - 5'd1;
    // Left shift stops at the minimum exponent, leaving a subnormal.
    if (sum[14]) begin
      m14 = {sum[14:2], sum[1] | sum[0]};
      en  = {1'b0, el} + 6'd1;
    end else begin
      sh  = ({1'b0, lz} > lim) ? lim : {1'b0, lz};
      m14 = sum[13:0] << sh;
      en  = m14[13] ? {1'b0, el - sh} : 6'd0;
    end
    rnd = m14[2] & (m14[1] | m14[0] | m14[3]);
    pre = {en, m14[12:3]} + {15'd0, rnd};
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) res = 16'h7E00;
    else if (a_inf) res = {sa, 5'h1F, 10'd0};
    else if (b_inf) res = {sb, 5'h1F, 10'd0};
    else if (sum == 15'd0) res = {sa & sb, 15'd0};
    else if (pre[15:10] >= 6'd31) res = {sl, 5'h1F, 10'd0};
`ifdef HALF_VEC_ADD_FTZ_EN
    else if (pre[15:10] == 6'd0) res = {sl, 15'd0};
`endif
    else res = {sl, pre[14:0]};
    return res;
  endfunction

  logic [15:0] vector_c_d [WIDTH];
  logic [15:0] vector_c_q [WIDTH];
  logic        done_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    assign vector_c_d[gi] = fp16_add(vector_a[gi], vector_b[gi]);
    assign vector_c[gi]   = vector_c_q[gi];
  end

  // Result bank and done pulse; reset wins over a coincident start.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      done_q <= 1'b0;
      for (int i = 0; i < WIDTH; i++) vector_c_q[i] <= 16'h0000;
    end else begin
      done_q <= start;
      for (int i = 0; i < WIDTH; i++) begin
        if (start) vector_c_q[i] <= vector_c_d[i];
        else       vector_c_q[i] <= vector_c_q[i];
      end
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_half_vec_add.sv
// Scoreboard bench for half_vec_add: directed lanes plus random vectors against a real-arithmetic model.
module tb_half_vec_add;
  localparam int WIDTH = 50;
  typedef logic [WIDTH-1:0][15:0] vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        done;
  logic [15:0] vector_a [WIDTH];
  logic [15:0] vector_b [WIDTH];
  logic [15:0] vector_c [WIDTH];

  int   checks = 0;
  int   failures = 0;
  vec_t exp_q [$];
  vec_t last_exp;

  always #5 clk = ~clk;

  half_vec_add #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rstn(rstn), .start(start),
    .vector_a(vector_a), .vector_b(vector_b),
    .done(done), .vector_c(vector_c)
  );

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) for (int j = 0; j < k; j++) r = r * 2.0;
    else for (int j = 0; j < -k; j++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v;
    int  e = int'(h[14:10]);
    int  m = int'(h[9:0]);
    if (e == 0) v = real'(m) * pow2(-24);
    else v = real'(1024 + m) * pow2(e - 25);
    return h[15] ? -v : v;
  endfunction

  // Exact real sum rounded to the binary16 grid, ties to even.
  function automatic logic [15:0] ref_add(input logic [15:0] a_in, input logic [15:0] b_in);
    logic [15:0] a, b, r;
    real x, ax, q, fr;
    int k, n, e;
    logic s;
    a = a_in;
    b = b_in;
`ifdef HALF_VEC_ADD_FTZ_EN
    if (a[14:10] == 5'd0) a = {a[15], 15'd0};
    if (b[14:10] == 5'd0) b = {b[15], 15'd0};
`endif
    if ((a[14:10] == 5'd31 && a[9:0] != 10'd0) || (b[14:10] == 5'd31 && b[9:0] != 10'd0)) return 16'h7E00;
    if (a[14:0] == 15'h7C00 && b[14:0] == 15'h7C00) return (a[15] != b[15]) ? 16'h7E00 : a;
    if (a[14:0] == 15'h7C00) return a;
    if (b[14:0] == 15'h7C00) return b;
    x = h2r(a) + h2r(b);
    if (x == 0.0) return {a[15] & b[15], 15'd0};
    s  = (x < 0.0);
    ax = s ? -x : x;
    k  = -14;
    for (int j = -14; j <= 16; j++) if (ax >= pow2(j)) k = j;
    q  = ax / pow2(k - 10);
    n  = int'($floor(q));
    fr = q - $floor(q);
    if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
    if (ax < pow2(-14)) r = {s, 15'(n)};
    else begin
      if (n == 2048) begin
        e = k + 16;
        n = 1024;
      end else e = k + 15;
      if (e >= 31) r = {s, 15'h7C00};
      else r = {s, 5'(e), 10'(n - 1024)};
    end
`ifdef HALF_VEC_ADD_FTZ_EN
    if (r[14:10] == 5'd0) r = {s, 15'd0};
`endif
    return r;
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] pick [6];
    logic [15:0] h;
    pick = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00, 16'h7E00, 16'h7BFF};
    case ($urandom_range(0, 7))
      0: h = 16'($urandom);
      1: h = {1'($urandom), 5'd0, 10'($urandom)};
      2: h = pick[$urandom_range(0, 5)];
      default: h = {1'($urandom), 5'($urandom_range(1, 30)), 10'($urandom)};
    endcase
    return h;
  endfunction

  task automatic chk16(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got %b expected %b", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t a, input vec_t b, input vec_t e);
    for (int i = 0; i < WIDTH; i++) begin
      vector_a[i] = a[i];
      vector_b[i] = b[i];
    end
    exp_q.push_back(e);
    last_exp = e;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic issue_random();
    vec_t a, b, e;
    for (int i = 0; i < WIDTH; i++) begin
      a[i] = rand_half();
      case ($urandom_range(0, 3))
        0: b[i] = a[i] ^ 16'h8000 ^ {14'd0, 2'($urandom)};
        default: b[i] = rand_half();
      endcase
      e[i] = ref_add(a[i], b[i]);
    end
    issue(a, b, e);
  endtask

  // Monitor: every done pops one expected vector.
  always @(negedge clk) begin : monitor
    vec_t e;
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL spurious_done got done=1 expected no pending result");
      end else begin
        e = exp_q.pop_front();
        for (int i = 0; i < WIDTH; i++) begin
          if (vector_c[i] !== e[i]) begin
            failures++;
            $display("FAIL vector_c[%0d] got %h expected %h", i, vector_c[i], e[i]);
          end
        end
      end
    end
  end

  logic [15:0] da [12] = '{16'h3C00, 16'h3C00, 16'h3C00, 16'h3C01, 16'h7BFF, 16'h7C00,
                           16'h7E01, 16'h8000, 16'h0001, 16'h0400, 16'h0000, 16'hFC00};
  logic [15:0] db [12] = '{16'hBC00, 16'h1000, 16'h1200, 16'h1000, 16'h7BFF, 16'hFC00,
                           16'h3C00, 16'h8000, 16'h0001, 16'h8001, 16'h8000, 16'h3C00};
`ifdef HALF_VEC_ADD_FTZ_EN
  logic [15:0] dc [12] = '{16'h0000, 16'h3C00, 16'h3C01, 16'h3C02, 16'h7C00, 16'h7E00,
                           16'h7E00, 16'h8000, 16'h0000, 16'h0400, 16'h0000, 16'hFC00};
`else
  logic [15:0] dc [12] = '{16'h0000, 16'h3C00, 16'h3C01, 16'h3C02, 16'h7C00, 16'h7E00,
                           16'h7E00, 16'h8000, 16'h0002, 16'h03FF, 16'h0000, 16'hFC00};
`endif

  initial begin
    vec_t a, b, e;
    for (int i = 0; i < WIDTH; i++) begin
      vector_a[i] = 16'h3C00;
      vector_b[i] = 16'h3C00;
    end
    // Reset held two cycles with start asserted: no result may appear.
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    chk1("reset_done", done, 1'b0);
    for (int i = 0; i < WIDTH; i++) chk16("reset_c", i, vector_c[i], 16'h0000);
    rstn = 1'b1;
    @(negedge clk);
    chk1("no_done_after_reset", done, 1'b0);

    // Directed lanes; remaining lanes 1.0 + 1.0.
    for (int i = 0; i < WIDTH; i++) begin
      a[i] = 16'h3C00;
      b[i] = 16'h3C00;
      e[i] = 16'h4000;
    end
    for (int i = 0; i < 12; i++) begin
      a[i] = da[i];
      b[i] = db[i];
      e[i] = dc[i];
    end
    @(posedge clk);
    #1;
    issue(a, b, e);
    @(negedge clk);
    chk1("done_pulse", done, 1'b1);
    @(negedge clk);
    chk1("done_fall", done, 1'b0);

    // Inputs change without start: outputs hold.
    for (int i = 0; i < WIDTH; i++) begin
      vector_a[i] = rand_half();
      vector_b[i] = rand_half();
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < WIDTH; i++) chk16("hold", i, vector_c[i], last_exp[i]);

    // Back-to-back requests.
    @(posedge clk);
    #1;
    issue_random();
    issue_random();
    @(negedge clk);
    chk1("b2b_done_second", done, 1'b1);
    @(negedge clk);
    chk1("b2b_done_fall", done, 1'b0);

    // Random traffic with random gaps.
    for (int n = 0; n < 60; n++) begin
      issue_random();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    // Reset right after a start clears the result.
    issue_random();
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk1("reset_after_start_done", done, 1'b0);
    for (int i = 0; i < WIDTH; i++) chk16("reset_after_start_c", i, vector_c[i], 16'h0000);

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_results got %0d expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
